ddr_wr_burst_arbiter: RTL and testbench
=======================================

// Module: ddr_wr_burst_arbiter
// PURPOSE
//  Read-clock-domain scheduler that shares one DDR write-command/data port between two
//  camera async FIFOs. Converts each synchronized Gray write pointer to a fill level and
//  grants a channel once it holds a full burst. Drains exactly BURST_LEN words per grant and
//  returns Gray read pointers for the write-side synchronizers. Sits between the stitcher's
//  two input FIFOs and the DDR write master.
// PARAMETERS
//  ASIZE        4            FIFO address width; depth = 2**ASIZE; pointers are ASIZE+1 bits
//  DW           32           FIFO/DDR data width, bits
//  AW           28           DDR byte address width
//  BURST_LEN    8            words per burst; power of 2, 1..2**ASIZE
//  FRAME_BURSTS 1024         bursts per frame buffer before the address wraps to base
//  BASE0        28'h0000000  DDR byte base address, channel 0
//  BASE1        28'h0800000  DDR byte base address, channel 1
// PORTS
//  rclk       in   1         read/DDR-side clock
//  rrst_n     in   1         asynchronous active-low reset
//  rq2_wptr0  in   ASIZE+1   ch0 write pointer, Gray, already 2-flop synchronized
//  rq2_wptr1  in   ASIZE+1   ch1 write pointer, Gray, already 2-flop synchronized
//  rptr0      out  ASIZE+1   ch0 read pointer, Gray, registered
//  rptr1      out  ASIZE+1   ch1 read pointer, Gray, registered
//  raddr0     out  ASIZE     ch0 FIFO RAM read address = rbin0[ASIZE-1:0]
//  raddr1     out  ASIZE     ch1 FIFO RAM read address
//  rd_en0     out  1         ch0 RAM read strobe; rdata0 valid next cycle
//  rd_en1     out  1         ch1 RAM read strobe
//  rdata0     in   DW        ch0 RAM read data, 1-cycle latency
//  rdata1     in   DW        ch1 RAM read data
//  cmd_valid  out  1         burst command valid
//  cmd_ready  in   1         DDR master accepts command
//  cmd_ch     out  1         granted channel
//  cmd_addr   out  AW        burst byte address
//  wr_valid   out  1         write data valid
//  wr_ready   in   1         DDR master accepts data
//  wr_data    out  DW        write data
//  wr_last    out  1         last beat of burst
// BEHAVIOUR
//  - Reset: all outputs 0 (rptrX/raddrX/rd_enX/cmd_*/wr_*); rbinX=0; addr counters=BASEX;
//    rr_last=1 (channel 0 wins first); FSM=IDLE.
//  - fillX = gray2bin(rq2_wptrX) - rbinX, ASIZE+1-bit modulo. eligX = (fillX >= BURST_LEN).
//  - FSM IDLE: if any elig, grant in the same cycle. Round-robin: both eligible -> !rr_last;
//    one eligible -> that one. Register cmd_ch, cmd_addr, cmd_valid=1 -> CMD.
//  - CMD: hold cmd_* stable until cmd_valid&cmd_ready, then -> DATA and set rr_last=cmd_ch.
//  - DATA: issue rd_enX for the granted channel only when buffered+in-flight words < 2
//    (2-entry output skid). Each rd_en increments rbinX; rptrX <= bin2gray(rbinX+1) on
//    the same edge. Beats leave on wr_valid&wr_ready. wr_last=1 on beat BURST_LEN.
//    After the last beat -> IDLE. Exactly BURST_LEN reads per grant; no underflow
//    (eligibility checked before grant, writer cannot decrease fill).
//  - Address: on command handshake, ch addr += BURST_LEN*DW/8; after FRAME_BURSTS
//    bursts, reload BASEX. Adder wraps modulo 2**AW.
//  - Full FIFO (fill==2**ASIZE) is legal and eligible. Pointer wrap uses the extra MSB.
//  - Back-to-back: IDLE may re-grant on the cycle after wr_last handshake; 1 idle cycle
//    between bursts.
//  - wr_ready low holds wr_data/wr_last stable; reads stall at 2 outstanding.
//  - Reset mid-burst: immediate abort, state as reset; DDR master must also be reset.
// CONFIGURATION
//  ARB_FILL_PRIORITY_EN defined: both eligible -> higher fill wins; tie -> round-robin.
//  Undefined: pure round-robin as above.
// STRUCTURE
//  Package vddr_pkg: gray2bin/bin2gray functions, FSM state localparams
//  (IDLE/CMD/DATA), BYTES_PER_BEAT.
//  Sub-module ddr_wr_skid2: 2-entry valid/ready buffer for RAM read data.
// TESTING (ASIZE=4, DW=32, BURST_LEN=8)
//  - Ch0 wptr=gray(7) -> no cmd; wptr=gray(8) -> cmd_valid, cmd_ch=0, cmd_addr=BASE0.
//  - Both fill=8 from reset -> grants 0,1,0,1; ch0 addrs BASE0, BASE0+32.
//  - wr_ready toggled 1/0 each cycle -> 8 beats in order, wr_last on beat 8 only,
//    rptr0 ends at gray(8).
//  - Ch0 writes 40 words with pointer wrap (wbin 16->0 MSB toggle) -> 5 bursts, rptr0 == wptr.
//  - FRAME_BURSTS=2: third ch1 burst cmd_addr=BASE1.
//  - Assert rrst_n low mid-DATA -> all outputs 0 next cycle.
//  - ARB_FILL_PRIORITY_EN: fill0=8, fill1=12 -> ch1 granted.

Source files
------------

// File: rtl/vddr_pkg.sv
// Shared types and helpers for the DDR write burst arbiter:
// Gray/binary pointer conversion, FSM state encoding and beat width.
package vddr_pkg;

    localparam int BYTES_PER_BEAT = 4;
    // Conversions work on a wide vector; callers zero-extend and truncate.
    localparam int PTR_MAX = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
        logic [PTR_MAX-1:0] b;
        b[PTR_MAX-1] = g[PTR_MAX-1];
        for (int i = PTR_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ddr_wr_skid2.sv
// Two-entry FIFO holding RAM read data until the DDR master takes it.
// The producer never pushes into a full buffer (it counts entries plus
// reads still in flight), so there is no input-side ready.
module ddr_wr_skid2
    import vddr_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    count
);

    logic [1:0][DW-1:0] mem;
    logic               wp;
    logic               rp;
    logic               push;
    logic               pop;

    assign push      = in_valid;
    assign pop       = out_valid & out_ready;
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rp];

    // Storage and pointers; head entry stays put while out_ready is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '0;
            wp    <= 1'b0;
            rp    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= in_data;
                wp      <= ~wp;
            end
            if (pop) begin
                rp <= ~rp;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/ddr_wr_burst_arbiter.sv
// Read-clock-domain scheduler sharing one DDR write port between two
// camera async FIFOs. A channel is granted once it holds a full burst;
// exactly BURST_LEN words are drained per grant.
// Optional: define ARB_FILL_PRIORITY_EN to let the fuller FIFO win when
// both are eligible (ties fall back to round-robin).
module ddr_wr_burst_arbiter
    import vddr_pkg::*;
#(
    parameter int          ASIZE        = 4,
    parameter int          DW           = BYTES_PER_BEAT * 8,
    parameter int          AW           = 28,
    parameter int          BURST_LEN    = 8,
    parameter int          FRAME_BURSTS = 1024,
    parameter logic [AW-1:0] BASE0      = AW'(28'h0000000),
    parameter logic [AW-1:0] BASE1      = AW'(28'h0800000)
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [ASIZE:0]   rq2_wptr0,
    input  logic [ASIZE:0]   rq2_wptr1,
    output logic [ASIZE:0]   rptr0,
    output logic [ASIZE:0]   rptr1,
    output logic [ASIZE-1:0] raddr0,
    output logic [ASIZE-1:0] raddr1,
    output logic             rd_en0,
    output logic             rd_en1,
    input  logic [DW-1:0]    rdata0,
    input  logic [DW-1:0]    rdata1,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic             cmd_ch,
    output logic [AW-1:0]    cmd_addr,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [DW-1:0]    wr_data,
    output logic             wr_last
);

    localparam int PW          = ASIZE + 1;
    localparam int BURST_BYTES = BURST_LEN * DW / 8;
    localparam int BCW         = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
    localparam int CW          = $clog2(BURST_LEN + 1);

    state_t             state, state_nxt;
    logic [1:0][PW-1:0] wbin, rbin, fill, rptr_q;
    logic [1:0]         elig;
    logic [1:0][AW-1:0] addr;
    logic [1:0][BCW-1:0] bcnt;
    logic               rr_last;
    logic               grant_ch;
    logic               cmd_fire, beat_fire, last_fire;
    logic               rd_go;
    logic [1:0]         rd_en_v;
    logic [CW-1:0]      rd_cnt, beat_cnt;
    logic               rd_inflight;
    logic [1:0]         skid_cnt;

    assign wbin[0] = PW'(gray2bin(PTR_MAX'(rq2_wptr0)));
    assign wbin[1] = PW'(gray2bin(PTR_MAX'(rq2_wptr1)));

    // Fill level per channel; the extra pointer MSB makes a full FIFO read as 2**ASIZE.
    always_comb begin
        fill = '0;
        elig = '0;
        for (int c = 0; c < 2; c++) begin
            fill[c] = wbin[c] - rbin[c];
            elig[c] = (fill[c] >= PW'(BURST_LEN));
        end
    end

    // Channel choice when granting from IDLE.
    always_comb begin
        grant_ch = elig[1];
        if (elig[0] && elig[1]) begin
`ifdef ARB_FILL_PRIORITY_EN
            if (fill[0] != fill[1]) grant_ch = (fill[1] > fill[0]);
            else                    grant_ch = ~rr_last;
`else
            grant_ch = ~rr_last;
`endif
        end
    end

    assign cmd_fire  = cmd_valid & cmd_ready;
    assign beat_fire = wr_valid & wr_ready;
    assign last_fire = beat_fire & wr_last;

    // Read only while buffered plus in-flight words stay below the skid depth.
    assign rd_go   = (state == DATA) && (rd_cnt < CW'(BURST_LEN)) &&
                     ((skid_cnt + 2'(rd_inflight)) < 2'd2);
    assign rd_en_v = {rd_go & cmd_ch, rd_go & ~cmd_ch};
    assign rd_en0  = rd_en_v[0];
    assign rd_en1  = rd_en_v[1];
    assign raddr0  = rbin[0][ASIZE-1:0];
    assign raddr1  = rbin[1][ASIZE-1:0];
    assign rptr0   = rptr_q[0];
    assign rptr1   = rptr_q[1];
    assign wr_last = wr_valid && (beat_cnt == CW'(BURST_LEN - 1));

    // State register.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; cmd_valid is high for the whole of CMD.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|elig)     state_nxt = CMD;
            CMD:     if (cmd_ready) state_nxt = DATA;
            DATA:    if (last_fire) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Command register, round-robin history and per-channel address counters.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            cmd_valid <= 1'b0;
            cmd_ch    <= 1'b0;
            cmd_addr  <= '0;
            rr_last   <= 1'b1;
            addr[0]   <= BASE0;
            addr[1]   <= BASE1;
            bcnt      <= '0;
        end else begin
            if (state == IDLE && |elig) begin
                cmd_valid <= 1'b1;
                cmd_ch    <= grant_ch;
                cmd_addr  <= addr[grant_ch];
            end else if (cmd_fire) begin
                cmd_valid <= 1'b0;
            end
            if (cmd_fire) begin
                rr_last <= cmd_ch;
                if (bcnt[cmd_ch] == BCW'(FRAME_BURSTS - 1)) begin
                    bcnt[cmd_ch] <= '0;
                    addr[cmd_ch] <= cmd_ch ? BASE1 : BASE0;
                end else begin
                    bcnt[cmd_ch] <= bcnt[cmd_ch] + BCW'(1);
                    addr[cmd_ch] <= addr[cmd_ch] + AW'(BURST_BYTES);
                end
            end
        end
    end

    // Read pointers: binary for the RAM address, Gray registered for the write side.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin   <= '0;
            rptr_q <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (rd_en_v[c]) begin
                    rbin[c]   <= rbin[c] + PW'(1);
                    rptr_q[c] <= PW'(bin2gray(PTR_MAX'(rbin[c] + PW'(1))));
                end
            end
        end
    end

    // Per-burst read and beat counters plus the RAM latency stage.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rd_cnt      <= '0;
            beat_cnt    <= '0;
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= rd_go;
            if (last_fire) begin
                rd_cnt   <= '0;
                beat_cnt <= '0;
            end else begin
                if (rd_go)     rd_cnt   <= rd_cnt + CW'(1);
                if (beat_fire) beat_cnt <= beat_cnt + CW'(1);
            end
        end
    end

    ddr_wr_skid2 #(.DW(DW)) u_skid (
        .clk       (rclk),
        .rst_n     (rrst_n),
        .in_valid  (rd_inflight),
        .in_data   (cmd_ch ? rdata1 : rdata0),
        .out_valid (wr_valid),
        .out_ready (wr_ready),
        .out_data  (wr_data),
        .count     (skid_cnt)
    );

endmodule

// File: tb/tb_ddr_wr_burst_arbiter.sv
// Directed bench for ddr_wr_burst_arbiter (ASIZE=4, DW=32, BURST_LEN=8,
// FRAME_BURSTS=2). Models both FIFO RAMs and the DDR master handshake.
module tb_ddr_wr_burst_arbiter;

    localparam logic [27:0] BASE0 = 28'h0000000;
    localparam logic [27:0] BASE1 = 28'h0800000;

    logic        rclk = 1'b0;
    logic        rrst_n = 1'b0;
    logic [4:0]  rq2_wptr0 = '0, rq2_wptr1 = '0;
    logic [4:0]  rptr0, rptr1;
    logic [3:0]  raddr0, raddr1;
    logic        rd_en0, rd_en1;
    logic [31:0] rdata0 = '0, rdata1 = '0;
    logic        cmd_valid, cmd_ch, cmd_ready = 1'b0;
    logic [27:0] cmd_addr;
    logic        wr_valid, wr_last, wr_ready = 1'b0;
    logic [31:0] wr_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [2][16];
    logic [4:0]  wbin [2];
    int          wk [2];
    int          rk [2];

    logic        obs_ch;
    logic [27:0] obs_addr;
    logic [31:0] obs_data [8];
    logic [7:0]  obs_last;
    bit          obs_to;
    int          obs_wait;
    int          obs_unstable;

    ddr_wr_burst_arbiter #(
        .ASIZE(4), .DW(32), .AW(28), .BURST_LEN(8), .FRAME_BURSTS(2),
        .BASE0(BASE0), .BASE1(BASE1)
    ) dut (
        .rclk(rclk), .rrst_n(rrst_n),
        .rq2_wptr0(rq2_wptr0), .rq2_wptr1(rq2_wptr1),
        .rptr0(rptr0), .rptr1(rptr1), .raddr0(raddr0), .raddr1(raddr1),
        .rd_en0(rd_en0), .rd_en1(rd_en1), .rdata0(rdata0), .rdata1(rdata1),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_addr(cmd_addr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last)
    );

    always #5 rclk = ~rclk;

    // FIFO RAMs with one-cycle read latency.
    always @(posedge rclk) begin
        if (rd_en0) rdata0 <= mem[0][raddr0];
        if (rd_en1) rdata1 <= mem[1][raddr1];
    end

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] dval(input int ch, input int k);
        return {(ch == 1) ? 16'hB1B1 : 16'hA0A0, k[15:0]};
    endfunction

    function automatic logic [83:0] all_outs();
        return {rptr0, rptr1, raddr0, raddr1, rd_en0, rd_en1, cmd_valid, cmd_ch,
                cmd_addr, wr_valid, wr_data, wr_last};
    endfunction

    task automatic write_words(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            mem[ch][wbin[ch][3:0]] = dval(ch, wk[ch]);
            wk[ch]++;
            wbin[ch] = wbin[ch] + 5'd1;
        end
        rq2_wptr0 = gray(wbin[0]);
        rq2_wptr1 = gray(wbin[1]);
    endtask

    task automatic do_reset();
        rrst_n = 1'b0;
        cmd_ready = 1'b0;
        wr_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            wbin[c] = '0; wk[c] = 0; rk[c] = 0;
        end
        rq2_wptr0 = '0;
        rq2_wptr1 = '0;
        repeat (2) @(negedge rclk);
        rrst_n = 1'b1;
        @(negedge rclk);
    endtask

    // Accepts one command and its data beats; records what was seen.
    task automatic collect(input bit toggle);
        int n, cyc;
        bit rdy, hold;
        logic [31:0] held;
        obs_to = 0; obs_wait = 0; obs_unstable = 0; obs_last = '0;
        held = '0; hold = 0;
        while (!cmd_valid && obs_wait < 50) begin
            @(negedge rclk);
            obs_wait++;
        end
        if (!cmd_valid) begin
            obs_to = 1;
            return;
        end
        obs_ch = cmd_ch;
        obs_addr = cmd_addr;
        cmd_ready = 1'b1;
        @(negedge rclk);
        cmd_ready = 1'b0;
        n = 0; cyc = 0; rdy = 1;
        while (n < 8 && cyc < 200) begin
            if (hold && (!wr_valid || wr_data !== held)) obs_unstable++;
            wr_ready = rdy;
            hold = 0;
            if (wr_valid && rdy) begin
                obs_data[n] = wr_data;
                obs_last[n] = wr_last;
                n++;
            end else if (wr_valid) begin
                hold = 1;
                held = wr_data;
            end
            @(negedge rclk);
            cyc++;
            if (toggle) rdy = ~rdy;
        end
        wr_ready = 1'b0;
        if (n < 8) obs_to = 1;
    endtask

    task automatic test_reset();
        rrst_n = 1'b0;
        repeat (2) @(negedge rclk);
        checks++;
        if (all_outs() !== 84'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        rrst_n = 1'b1;
    endtask

    task automatic test_threshold();
        int bad;
        do_reset();
        write_words(0, 7);
        repeat (4) @(negedge rclk);
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++; $display("FAIL below_burst_no_cmd: cmd_valid %b expected 0", cmd_valid);
        end
        write_words(0, 1);
        @(negedge rclk);
        checks++;
        if ({cmd_valid, cmd_ch, cmd_addr} !== {1'b1, 1'b0, BASE0}) begin
            errors++;
            $display("FAIL grant_at_burst: valid/ch/addr %b/%b/%h expected 1/0/%h",
                     cmd_valid, cmd_ch, cmd_addr, BASE0);
        end
        repeat (3) @(negedge rclk);
        checks++;
        if ({cmd_valid, cmd_ch, cmd_addr} !== {1'b1, 1'b0, BASE0}) begin
            errors++;
            $display("FAIL cmd_hold: valid/ch/addr %b/%b/%h expected 1/0/%h",
                     cmd_valid, cmd_ch, cmd_addr, BASE0);
        end
        collect(0);
        checks++;
        if (obs_to) begin
            errors++; $display("FAIL thr_burst: timeout got 1 expected 0");
        end
        bad = 0;
        for (int j = 0; j < 8; j++) if (obs_data[j] !== dval(0, rk[0] + j)) bad++;
        rk[0] += 8;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL thr_data: %0d wrong words, got %h expected %h", bad, obs_data[0], dval(0, 0));
        end
        checks++;
        if (obs_last !== 8'h80) begin
            errors++; $display("FAIL thr_last: got %b expected 10000000", obs_last);
        end
        checks++;
        if (rptr0 !== gray(5'd8)) begin
            errors++; $display("FAIL thr_rptr0: got %b expected %b", rptr0, gray(5'd8));
        end
    endtask

    task automatic test_round_robin();
        int bad, ec;
        logic [27:0] ea;
        do_reset();
        write_words(0, 16);
        write_words(1, 16);
        for (int i = 0; i < 4; i++) begin
            collect(0);
            ec = i % 2;
            ea = ((ec == 1) ? BASE1 : BASE0) + 28'(32 * (i / 2));
            checks++;
            if (obs_to || obs_ch !== ec[0] || obs_addr !== ea) begin
                errors++;
                $display("FAIL rr_grant%0d: timeout/ch/addr %b/%b/%h expected 0/%b/%h",
                         i, obs_to, obs_ch, obs_addr, ec[0], ea);
            end
            bad = 0;
            for (int j = 0; j < 8; j++) if (obs_data[j] !== dval(ec, rk[ec] + j)) bad++;
            rk[ec] += 8;
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL rr_data%0d: %0d wrong words, got %h", i, bad, obs_data[0]);
            end
            if (i > 0) begin
                checks++;
                if (obs_wait !== 1) begin
                    errors++; $display("FAIL back_to_back%0d: idle cycles %0d expected 1", i, obs_wait);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset();
        write_words(0, 8);
        collect(1);
        bad = 0;
        for (int j = 0; j < 8; j++) if (obs_data[j] !== dval(0, j)) bad++;
        checks++;
        if (obs_to || bad != 0) begin
            errors++; $display("FAIL bp_data: timeout %b, %0d wrong words, expected 0 and 0", obs_to, bad);
        end
        checks++;
        if (obs_last !== 8'h80) begin
            errors++; $display("FAIL bp_last: got %b expected 10000000", obs_last);
        end
        checks++;
        if (obs_unstable !== 0) begin
            errors++; $display("FAIL bp_stall_stable: %0d changes expected 0", obs_unstable);
        end
        checks++;
        if (rptr0 !== gray(5'd8)) begin
            errors++; $display("FAIL bp_rptr0: got %b expected %b", rptr0, gray(5'd8));
        end
    endtask

    task automatic test_pointer_wrap();
        int bad, done;
        do_reset();
        write_words(0, 16);
        bad = 0; done = 0;
        for (int b = 0; b < 5; b++) begin
            collect(0);
            if (!obs_to) done++;
            if (obs_ch !== 1'b0 || obs_addr !== BASE0 + 28'(32 * (b % 2))) bad++;
            for (int j = 0; j < 8; j++) if (obs_data[j] !== dval(0, rk[0] + j)) bad++;
            rk[0] += 8;
            if (b < 3) write_words(0, 8);
        end
        checks++;
        if (done !== 5) begin
            errors++; $display("FAIL wrap_bursts: got %0d expected 5", done);
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL wrap_data: %0d mismatched items expected 0", bad);
        end
        checks++;
        if (rptr0 !== rq2_wptr0 || rptr0 !== gray(5'd8)) begin
            errors++; $display("FAIL wrap_rptr0: got %b expected %b", rptr0, rq2_wptr0);
        end
        repeat (3) @(negedge rclk);
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++; $display("FAIL wrap_drained: cmd_valid %b expected 0", cmd_valid);
        end
    endtask

    task automatic test_frame_wrap();
        logic [27:0] ea [3];
        ea[0] = BASE1; ea[1] = BASE1 + 28'd32; ea[2] = BASE1;
        do_reset();
        write_words(1, 16);
        for (int b = 0; b < 3; b++) begin
            collect(0);
            checks++;
            if (obs_to || obs_ch !== 1'b1 || obs_addr !== ea[b]) begin
                errors++;
                $display("FAIL frame_addr%0d: timeout/ch/addr %b/%b/%h expected 0/1/%h",
                         b, obs_to, obs_ch, obs_addr, ea[b]);
            end
            if (b == 1) write_words(1, 8);
        end
    endtask

    task automatic test_fill_arb();
        logic ec;
`ifdef ARB_FILL_PRIORITY_EN
        ec = 1'b1;
`else
        ec = 1'b0;
`endif
        do_reset();
        write_words(0, 8);
        write_words(1, 12);
        @(negedge rclk);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_ch !== ec) begin
            errors++; $display("FAIL fill_arb: valid/ch %b/%b expected 1/%b", cmd_valid, cmd_ch, ec);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        do_reset();
        write_words(0, 8);
        w = 0;
        while (!cmd_valid && w < 20) begin
            @(negedge rclk);
            w++;
        end
        checks++;
        if (!cmd_valid) begin
            errors++; $display("FAIL mid_cmd: cmd_valid 0 expected 1");
        end
        cmd_ready = 1'b1;
        @(negedge rclk);
        cmd_ready = 1'b0;
        repeat (3) @(negedge rclk);
        checks++;
        if (wr_valid !== 1'b1) begin
            errors++; $display("FAIL mid_active: wr_valid %b expected 1", wr_valid);
        end
        rrst_n = 1'b0;
        @(negedge rclk);
        checks++;
        if (all_outs() !== 84'd0) begin
            errors++; $display("FAIL mid_reset_outputs: got %h expected 0", all_outs());
        end
        rrst_n = 1'b1;
        @(negedge rclk);
    endtask

    initial begin
        for (int c = 0; c < 2; c++) begin
            wbin[c] = '0; wk[c] = 0; rk[c] = 0;
            for (int i = 0; i < 16; i++) mem[c][i] = '0;
        end
        test_reset();
        test_threshold();
        test_round_robin();
        test_backpressure();
        test_pointer_wrap();
        test_frame_wrap();
        test_fill_arb();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
